// File: rtl/serial_mac_gen_if.sv
// Serial MAC request/response bundle.
// master drives operands and start, slave returns the result stream.
interface serial_mac_gen_if;
  logic start;
  logic clear_acc;
  logic a_sin;
  logic b_sin;
  logic busy;
  logic res_sout;
  logic res_valid;
  logic carry_out;
  logic finish;

  modport master (
    output start, clear_acc, a_sin, b_sin,
    input  busy, res_sout, res_valid,
    input  carry_out, finish
  );

  modport slave (
    input  start, clear_acc, a_sin, b_sin,
    output busy, res_sout, res_valid,
    output carry_out, finish
  );
endinterface

// File: rtl/serial_mac_gen.sv
// Bit-serial unsigned multiply-accumulate.
// Operands load LSB first, the accumulator streams out LSB first.
module serial_mac_gen #(
  parameter int OP_W  = 8,
  parameter int ACC_W = 20
) (
  input logic             clk,
  input logic             reset_n,
  serial_mac_gen_if.slave io
);

  localparam int MAXW  = (OP_W > ACC_W) ? OP_W : ACC_W;
  localparam int CNT_W = $clog2(MAXW);
  localparam int PW    = 2 * OP_W;

  if (OP_W < 2 || OP_W > 32) begin : g_op_chk
    $error("serial_mac_gen: OP_W must be 2..32");
  end
  if (ACC_W < 2 * OP_W) begin : g_acc_chk
    $error("serial_mac_gen: ACC_W must be >= 2*OP_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ACC,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              clr_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  acc;
  logic              carry;

  logic              op_last;
  logic              acc_last;
  logic [OP_W-1:0]   b_sh;
  logic [ACC_W-1:0]  acc_sh;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    sum;

  assign op_last  = (cnt == CNT_W'(OP_W - 1));
  assign acc_last = (cnt == CNT_W'(ACC_W - 1));
  assign b_sh     = b_q >> cnt;
  assign acc_sh   = acc >> cnt;
  assign acc_base = clr_q ? '0 : acc;
  assign sum      = {1'b0, acc_base}
                  + (ACC_W + 1)'(prod);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (io.start) state_nx = S_LOAD;
      S_LOAD: if (op_last)  state_nx = S_MUL;
      S_MUL:  if (op_last)  state_nx = S_ACC;
      S_ACC:                state_nx = S_OUT;
      S_OUT:  if (acc_last) state_nx = S_DONE;
      S_DONE:               state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    io.busy      = (state != S_IDLE);
    io.res_valid = 1'b0;
    io.res_sout  = 1'b0;
    io.finish    = 1'b0;
    io.carry_out = carry;
    unique case (state)
      S_OUT: begin
        io.res_valid = 1'b1;
        io.res_sout  = acc_sh[0];
      end
      S_DONE:  io.finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      clr_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      prod  <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (io.start) begin
          cnt   <= '0;
          clr_q <= io.clear_acc;
          a_q   <= '0;
          b_q   <= '0;
          prod  <= '0;
          if (io.clear_acc) carry <= 1'b0;
        end
        S_LOAD: begin
          a_q <= a_q | (OP_W'(io.a_sin) << cnt);
          b_q <= b_q | (OP_W'(io.b_sin) << cnt);
          cnt <= op_last ? '0 : cnt + 1'b1;
        end
        S_MUL: begin
          if (b_sh[0])
            prod <= prod + (PW'(a_q) << cnt);
          cnt <= op_last ? '0 : cnt + 1'b1;
        end
        S_ACC: begin
          acc <= sum[ACC_W-1:0];
          if (sum[ACC_W]) carry <= 1'b1;
          cnt <= '0;
        end
        S_OUT:   cnt <= acc_last ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_mac_gen.md
SERIAL_MAC_GEN -- requirements
Module: serial_mac_gen

Interface
REQ-001 The block SHALL have parameter OP_W, default 8, giving operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter ACC_W, default 20, giving accumulator width in bits; ACC_W >= 2*OP_W, with an elaboration-time error otherwise.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-006 The block SHALL have port clear_acc, input, 1, sampled with start; 1 = discard the old accumulator before adding.
REQ-007 The block SHALL have port a_sin, input, 1, serial operand A, LSB first.
REQ-008 The block SHALL have port b_sin, input, 1, serial operand B, LSB first.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port res_sout, output, 1, serial accumulator value, LSB first.
REQ-011 The block SHALL have port res_valid, output, 1, high while res_sout carries a result bit.
REQ-012 The block SHALL have port carry_out, output, 1, sticky accumulator overflow flag.
REQ-013 The block SHALL have port finish, output, 1, one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, MUL, ACC, OUT and DONE, with a single up-counter sized for max(OP_W, ACC_W).
REQ-015 In IDLE, a rising edge with start=1 SHALL go to LOAD, clear the counter, and latch clear_acc; start=0 SHALL hold IDLE.
REQ-016 In LOAD, each of the next OP_W edges SHALL shift a_sin and b_sin into bit position k (k = 0..OP_W-1); after bit OP_W-1, the FSM SHALL go to MUL.
REQ-017 MUL SHALL be an unsigned shift-add over exactly OP_W edges: if the current B bit is 1, the 2*OP_W-bit product register adds A shifted left by k; after OP_W edges, the FSM SHALL go to ACC.
REQ-018 ACC SHALL take one edge: acc <= (clear_latched ? 0 : acc) + zero-extended product, truncated to ACC_W bits.
REQ-019 In ACC, an addition carry out of bit ACC_W-1 SHALL set carry_out; carry_out SHALL clear only on reset or on an accepted start with clear_acc=1.
REQ-020 OUT SHALL last ACC_W cycles; in cycle i, res_sout = acc[i] and res_valid=1; after cycle ACC_W-1, the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with finish=1, then the FSM SHALL go to IDLE.
REQ-022 Latency SHALL be 2*OP_W+ACC_W+3 edges from the start-sampling edge to the edge that returns the FSM to IDLE (OP_W=8, ACC_W=20: 39).
REQ-023 The accumulator SHALL persist across operations; operands and product SHALL be cleared at each accepted start.
REQ-024 start SHALL be ignored in every state except IDLE, with no effect on the operation in progress.
REQ-025 Outside OUT, res_sout and res_valid SHALL be 0; finish SHALL be 0 outside DONE.
REQ-026 A product of 0 (either operand zero) SHALL still run the full MUL/ACC/OUT sequence.

Reset
REQ-027 reset_n=0 SHALL, asynchronously and in any state, force IDLE with the counter, operands, product, accumulator and carry_out at 0, and busy, res_sout, res_valid and finish at 0.
REQ-028 Reset mid-operation SHALL discard that operation with no finish pulse; after release, the block SHALL accept a new start on the first edge.

Verification (OP_W=8, ACC_W=20)
REQ-029 Reset, then start with clear_acc=1 and A=3, B=5: res_sout stream = 15 (0x0000F) over 20 cycles, finish at edge 39, carry_out=0.
REQ-030 Two operations 255*255 (clear_acc=1, then clear_acc=0): second stream = 130050 (0x1FC02).
REQ-031 17 consecutive 255*255 operations, the first with clear_acc=1: final stream = 56849 (0x0DE11) with carry_out=1; an 18th operation with clear_acc=0 keeps carry_out=1.
REQ-032 Pulse start during LOAD, MUL and OUT of a 7*9 operation: a single operation only, result 63, a single finish pulse.
REQ-033 Assert reset_n=0 during MUL: outputs 0 immediately, no finish; then 2*4 with clear_acc=0 streams 8.
REQ-034 A=0, B=200 with clear_acc=0 after an accumulator value of 100: stream 100, full 39-cycle latency.
